// File: rtl/display_pkg.sv
// Shared definitions for the four-digit scoreboard/timer display scan logic.
// Digit slot encodings (the value driven onto {clky, clkz}), the blank code
// sent to the segment decoder, the digit count, and the per-slot blanking rule.
package display_pkg;

    typedef enum logic [1:0] {
        SEL_PD = 2'b00,   // placar dezena (score tens)
        SEL_PU = 2'b01,   // placar unidade (score units)
        SEL_TD = 2'b10,   // tempo dezena (time tens)
        SEL_TU = 2'b11    // tempo unidade (time units)
    } slot_t;

    localparam logic [3:0] BCD_BLANK  = 4'hF;
    localparam int         NUM_DIGITS = 4;

    // A slot is dark when its value is not a decimal digit, or when it is a
    // leading zero (tens position of score or time) and suppression is on.
    function automatic logic digit_blank(input slot_t      slot,
                                         input logic [3:0] val,
                                         input logic       blank_lz);
        return (val > 4'd9) ||
               (blank_lz && (val == 4'd0) && ((slot == SEL_PD) || (slot == SEL_TD)));
    endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Free-running divider producing a one-cycle tick every DIV enabled clocks.
// Ports:
//   clk  - system clock
//   rst  - synchronous active-high reset, clears the count
//   en   - count enable; the count holds while low
//   tick - high during the cycle the count sits at DIV-1 (with en high)
module scan_prescaler #(
    parameter int DIV = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int             CW   = (DIV < 2) ? 1 : $clog2(DIV);
    localparam logic [CW-1:0]  LAST = CW'(DIV - 1);

    logic [CW-1:0] count;

    assign tick = en && (count == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (en) begin
            count <= tick ? '0 : count + CW'(1);
        end
    end

endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed scan controller for the four-digit scoreboard/timer display.
// Cycles the digit select, presents the selected digit's BCD value, and drives
// the active-low digit enable x with anti-ghosting guard time, leading-zero
// blanking and a per-frame snapshot of the digit inputs.
// Ports:
//   clk, rst      - clock and synchronous active-high reset
//   en            - scan enable; low freezes the scan and darkens the display
//   blank_lz      - suppress leading zero on pd and td (sampled every cycle)
//   bcd_pd..tu    - live digit values
//   clky, clkz    - registered digit select {MSB, LSB} to the demux
//   x             - registered digit enable, 0 lights the selected digit
//   digit_bcd     - registered BCD of the selected digit, 4'hF when dark
//   frame_start   - one-cycle pulse on entry to the pd slot
module display_scan_ctrl
    import display_pkg::*;
#(
    parameter int DIV   = 50000,
    parameter int GUARD = 500
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       blank_lz,
    input  logic [3:0] bcd_pd,
    input  logic [3:0] bcd_pu,
    input  logic [3:0] bcd_td,
    input  logic [3:0] bcd_tu,
    output logic       clky,
    output logic       clkz,
    output logic       x,
    output logic [3:0] digit_bcd,
    output logic       frame_start
);

    localparam int            GW       = (GUARD < 1) ? 1 : $clog2(GUARD + 1);
    localparam logic [GW-1:0] GUARD_LD = GW'(GUARD);

    logic tick;

    scan_prescaler #(.DIV(DIV)) u_pre (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .tick (tick)
    );

    slot_t                         sel,   sel_nxt;
    logic [NUM_DIGITS-1:0][3:0]    snap,  snap_nxt;
    logic [NUM_DIGITS-1:0][3:0]    frame_in;
    logic [GW-1:0]                 guard, guard_nxt;
    logic                          x_nxt, fs_nxt, blank_nxt;
    logic [3:0]                    dig_nxt, val_nxt;

    // Index 0 is pd so the array lines up with the slot encoding.
    assign frame_in = {bcd_tu, bcd_td, bcd_pu, bcd_pd};

    always_comb begin
        sel_nxt   = sel;
        snap_nxt  = snap;
        guard_nxt = guard;
        fs_nxt    = 1'b0;
        x_nxt     = 1'b1;
        dig_nxt   = digit_bcd;
        val_nxt   = snap[sel];
        blank_nxt = 1'b0;

        if (!en) begin
            // Frozen: everything holds, the display goes dark.
            x_nxt = 1'b1;
        end else if (tick) begin
            sel_nxt = slot_t'(sel + 2'd1);
            // Entering pd latches a fresh frame; pd shows the value captured
            // on this same edge, so read through snap_nxt.
            if (sel_nxt == SEL_PD) begin
                snap_nxt = frame_in;
                fs_nxt   = 1'b1;
            end
            val_nxt   = snap_nxt[sel_nxt];
            blank_nxt = digit_blank(sel_nxt, val_nxt, blank_lz);
            guard_nxt = GUARD_LD;
            dig_nxt   = blank_nxt ? BCD_BLANK : val_nxt;
            x_nxt     = (GUARD != 0) || blank_nxt;
        end else begin
            guard_nxt = (guard != '0) ? guard - GW'(1) : '0;
            blank_nxt = digit_blank(sel, val_nxt, blank_lz);
            dig_nxt   = blank_nxt ? BCD_BLANK : val_nxt;
            x_nxt     = (guard_nxt != '0) || blank_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sel         <= SEL_PD;
            snap        <= '0;
            guard       <= GUARD_LD;
            x           <= 1'b1;
            digit_bcd   <= '0;
            frame_start <= 1'b0;
        end else begin
            sel         <= sel_nxt;
            snap        <= snap_nxt;
            guard       <= guard_nxt;
            x           <= x_nxt;
            digit_bcd   <= dig_nxt;
            frame_start <= fs_nxt;
        end
    end

    assign {clky, clkz} = sel;

endmodule
